// File: rtl/aes_pkg.sv
// Shared AES output-path types: block/word widths, typedefs and serializer state.
package aes_pkg;

    localparam int AES_BLOCK_W         = 128;
    localparam int AES_WORD_W          = 32;
    localparam int AES_WORDS_PER_BLOCK = 4;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;
    typedef logic [AES_WORD_W-1:0]  aes_word_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    // Most-significant word goes out first.
    function automatic aes_word_t block_word(input aes_block_t blk, input logic [1:0] idx);
        aes_word_t w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// DEPTH-entry register FIFO of 128-bit blocks; head entry is read combinationally.
module aes_blk_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  aes_block_t    wr_data,
    output aes_block_t    head,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    aes_block_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [LW-1:0] level_reg;

    // Storage carries no reset: level gates every read, so stale entries never leak.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                level_reg <= level_reg + 1'b1;
            end else if (pop && !push) begin
                level_reg <= level_reg - 1'b1;
            end
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign level = level_reg;
    assign full  = (level_reg == LW'(DEPTH));
    assign empty = (level_reg == '0);

endmodule

// File: rtl/aes_out_serializer.sv
// Buffers AES result blocks and streams them as four 32-bit words over valid/ready.
// Optional AES_OUT_PARITY_EN adds ser_parity (even parity of ser_data).
module aes_out_serializer
    import aes_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          AES_clk,
    input  logic          AES_rst_n,
    input  logic          AES_data_out_valid,
    input  logic [127:0]  AES_data_out,
    output logic [31:0]   ser_data,
    output logic          ser_valid,
    input  logic          ser_ready,
    output logic          ser_last,
    output logic [LW-1:0] ser_level,
    output logic          ser_overflow,
    input  logic          ser_clr
`ifdef AES_OUT_PARITY_EN
    ,
    output logic          ser_parity
`endif
);

    localparam logic [1:0] LAST_IDX = 2'(AES_WORDS_PER_BLOCK - 1);

    ser_state_t    state_reg;
    logic          ser_valid_reg;
    logic [1:0]    idx_reg;
    logic          valid_d_reg;
    logic          overflow_reg;

    logic          capture;
    logic          xfer;
    logic          pop;
    logic          push;
    aes_block_t    head;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;

    assign capture = AES_data_out_valid & ~valid_d_reg;
    assign xfer    = ser_valid_reg & ser_ready;
    assign pop     = xfer & (idx_reg == LAST_IDX);
    // A pop this cycle frees the head slot, so a full buffer can still accept.
    assign push    = capture & (~full | pop);

    aes_blk_fifo #(
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk     (AES_clk),
        .rst_n   (AES_rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (AES_data_out),
        .head    (head),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    // valid_d resets high so a level already asserted at reset release is not an edge.
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            valid_d_reg  <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            valid_d_reg <= AES_data_out_valid;
            if (capture && full && !pop) begin
                overflow_reg <= 1'b1;
            end else if (ser_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            state_reg     <= IDLE;
            ser_valid_reg <= 1'b0;
            idx_reg       <= 2'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (push) begin
                        state_reg     <= SEND;
                        ser_valid_reg <= 1'b1;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        idx_reg <= idx_reg + 2'd1;
                        // Leave SEND only when the popped block was the last one held.
                        if (pop && (level == LW'(1)) && !push) begin
                            state_reg     <= IDLE;
                            ser_valid_reg <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    ser_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign ser_valid    = ser_valid_reg;
    assign ser_last     = ser_valid_reg & (idx_reg == LAST_IDX);
    assign ser_data     = empty ? '0 : block_word(head, idx_reg);
    assign ser_level    = level;
    assign ser_overflow = overflow_reg;

`ifdef AES_OUT_PARITY_EN
    assign ser_parity = ^ser_data;
`endif

endmodule

// File: tb/tb_aes_out_serializer.sv
// Directed bench for aes_out_serializer (DEPTH=2); expected words taken from hand-written blocks.
module tb_aes_out_serializer;

    localparam int DEPTH = 2;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          AES_clk = 1'b0;
    logic          AES_rst_n;
    logic          AES_data_out_valid;
    logic [127:0]  AES_data_out;
    logic [31:0]   ser_data;
    logic          ser_valid;
    logic          ser_ready;
    logic          ser_last;
    logic [LW-1:0] ser_level;
    logic          ser_overflow;
    logic          ser_clr;
`ifdef AES_OUT_PARITY_EN
    logic          ser_parity;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [127:0] B0 = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    localparam logic [127:0] B1 = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] B2 = 128'hdeadbeef_cafef00d_01234567_89abcdef;

    aes_out_serializer #(.DEPTH(DEPTH), .LW(LW)) dut (
        .AES_clk            (AES_clk),
        .AES_rst_n          (AES_rst_n),
        .AES_data_out_valid (AES_data_out_valid),
        .AES_data_out       (AES_data_out),
        .ser_data           (ser_data),
        .ser_valid          (ser_valid),
        .ser_ready          (ser_ready),
        .ser_last           (ser_last),
        .ser_level          (ser_level),
        .ser_overflow       (ser_overflow),
        .ser_clr            (ser_clr)
`ifdef AES_OUT_PARITY_EN
        ,
        .ser_parity         (ser_parity)
`endif
    );

    always #5 AES_clk = ~AES_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("  ok %s = %0h", tag, obs);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [127:0] blk, input int w);
        logic [127:0] t;
        t = blk << (32 * w);
        return t[127:96];
    endfunction

    task automatic check_word(input string tag, input logic [127:0] blk, input int w);
        check($sformatf("%s.w%0d.valid", tag, w), 128'(ser_valid), 128'(1));
        check($sformatf("%s.w%0d.data", tag, w), 128'(ser_data), 128'(word_of(blk, w)));
        check($sformatf("%s.w%0d.last", tag, w), 128'(ser_last), 128'(w == 3));
`ifdef AES_OUT_PARITY_EN
        check($sformatf("%s.w%0d.parity", tag, w), 128'(ser_parity), 128'(^word_of(blk, w)));
`endif
    endtask

    // Consumer ready every cycle; expects words first..3 of blk on consecutive cycles.
    task automatic expect_block(input string tag, input logic [127:0] blk, input int first);
        for (int w = first; w < 4; w++) begin
            @(posedge AES_clk); #1;
            ser_ready = 1'b1;
            @(negedge AES_clk);
            check_word(tag, blk, w);
        end
    endtask

    task automatic pulse(input logic [127:0] blk);
        @(posedge AES_clk); #1;
        AES_data_out_valid = 1'b1;
        AES_data_out       = blk;
        @(posedge AES_clk); #1;
        AES_data_out_valid = 1'b0;
    endtask

    task automatic expect_idle(input string tag);
        @(posedge AES_clk); #1;
        @(negedge AES_clk);
        check({tag, ".valid"}, 128'(ser_valid), 128'(0));
        check({tag, ".level"}, 128'(ser_level), 128'(0));
        check({tag, ".data"},  128'(ser_data),  128'(0));
    endtask

    initial begin
        logic [1:0] pat;
        int         idx;
        logic [127:0] d;

        AES_rst_n          = 1'b0;
        AES_data_out_valid = 1'b0;
        AES_data_out       = '0;
        ser_ready          = 1'b0;
        ser_clr            = 1'b0;

        // Reset state
        repeat (2) @(posedge AES_clk);
        #1;
        check("rst.valid",    128'(ser_valid),    128'(0));
        check("rst.last",     128'(ser_last),     128'(0));
        check("rst.level",    128'(ser_level),    128'(0));
        check("rst.overflow", 128'(ser_overflow), 128'(0));
        check("rst.data",     128'(ser_data),     128'(0));
        @(posedge AES_clk); #1;
        AES_rst_n = 1'b1;
        repeat (2) @(posedge AES_clk);

        // 1: single FIPS-197 block at full throughput
        #1;
        ser_ready          = 1'b1;
        AES_data_out_valid = 1'b1;
        AES_data_out       = B0;
        @(negedge AES_clk);
        check("t1.capture_cycle.valid", 128'(ser_valid), 128'(0));
        for (int w = 0; w < 4; w++) begin
            @(posedge AES_clk); #1;
            @(negedge AES_clk);
            check_word("t1", B0, w);
            check($sformatf("t1.w%0d.level", w), 128'(ser_level), 128'(1));
        end
        expect_idle("t1.after");
        AES_data_out_valid = 1'b0;

        // 2: same block with ready pattern 1,0,0,1
        ser_ready = 1'b0;
        @(posedge AES_clk); #1;
        AES_data_out_valid = 1'b1;
        AES_data_out       = B0;
        idx = 0;
        for (int c = 0; c < 32 && idx < 4; c++) begin
            @(posedge AES_clk); #1;
            pat       = 2'(c % 4);
            ser_ready = (pat == 2'd0) || (pat == 2'd3);
            @(negedge AES_clk);
            check_word("t2", B0, idx);
            if (ser_ready) idx++;
        end
        check("t2.words_sent", 128'(idx), 128'(4));
        AES_data_out_valid = 1'b0;
        expect_idle("t2.after");

        // 3: three blocks, no ready -> third dropped, overflow sticky until clear
        ser_ready = 1'b0;
        pulse(B0);
        pulse(B1);
        pulse(B2);
        @(negedge AES_clk);
        check("t3.level",    128'(ser_level),    128'(2));
        check("t3.overflow", 128'(ser_overflow), 128'(1));
        check_word("t3.head", B0, 0);
        @(posedge AES_clk); #1;
        ser_clr = 1'b1;
        @(posedge AES_clk); #1;
        ser_clr = 1'b0;
        @(negedge AES_clk);
        check("t3.clr.overflow", 128'(ser_overflow), 128'(0));
        expect_block("t3.b0", B0, 0);
        expect_block("t3.b1", B1, 0);
        expect_idle("t3.after");

        // 4: full buffer, head word3 accepted on the same cycle as a new capture edge
        ser_ready = 1'b0;
        pulse(B0);
        pulse(B1);
        @(negedge AES_clk);
        check("t4.full.level", 128'(ser_level), 128'(2));
        for (int w = 0; w < 4; w++) begin
            @(posedge AES_clk); #1;
            ser_ready          = 1'b1;
            AES_data_out_valid = (w == 3);
            AES_data_out       = B2;
            @(negedge AES_clk);
            check_word("t4.b0", B0, w);
            check($sformatf("t4.b0.w%0d.level", w), 128'(ser_level), 128'(2));
        end
        @(posedge AES_clk); #1;
        AES_data_out_valid = 1'b0;
        @(negedge AES_clk);
        check("t4.swap.level",    128'(ser_level),    128'(2));
        check("t4.swap.overflow", 128'(ser_overflow), 128'(0));
        check_word("t4.b1", B1, 0);
        expect_block("t4.b1", B1, 1);
        expect_block("t4.b2", B2, 0);
        expect_idle("t4.after");

        // 5: valid held 10 cycles with changing data -> only edge-cycle value emitted
        ser_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge AES_clk); #1;
            AES_data_out_valid = 1'b1;
            AES_data_out       = {32'h11110000 + 32'(c), 32'h22220000 + 32'(c),
                                  32'h33330000 + 32'(c), 32'h44440000 + 32'(c)};
            @(negedge AES_clk);
            if (c >= 1 && c <= 4) begin
                check_word("t5.hold", 128'h11110000_22220000_33330000_44440000, c - 1);
            end else begin
                check($sformatf("t5.hold.c%0d.valid", c), 128'(ser_valid), 128'(0));
            end
        end
        @(posedge AES_clk); #1;
        AES_data_out_valid = 1'b0;
        @(negedge AES_clk);
        check("t5.low.valid", 128'(ser_valid), 128'(0));
        d = 128'h55555555_66666666_77777777_88888888;
        @(posedge AES_clk); #1;
        AES_data_out_valid = 1'b1;
        AES_data_out       = d;
        expect_block("t5.reedge", d, 0);
        AES_data_out_valid = 1'b0;
        expect_idle("t5.after");

        // 6: reset after word1; valid high through release must not capture
        @(posedge AES_clk); #1;
        AES_data_out_valid = 1'b1;
        AES_data_out       = B0;
        ser_ready          = 1'b1;
        @(posedge AES_clk); #1;
        @(negedge AES_clk);
        check_word("t6", B0, 0);
        @(posedge AES_clk); #1;
        @(negedge AES_clk);
        check_word("t6", B0, 1);
        @(posedge AES_clk); #1;
        AES_rst_n = 1'b0;
        #1;
        check("t6.rst.valid", 128'(ser_valid), 128'(0));
        check("t6.rst.level", 128'(ser_level), 128'(0));
        check("t6.rst.last",  128'(ser_last),  128'(0));
        check("t6.rst.data",  128'(ser_data),  128'(0));
        @(posedge AES_clk); #1;
        AES_rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge AES_clk); #1;
            @(negedge AES_clk);
            check($sformatf("t6.held.c%0d.valid", c), 128'(ser_valid), 128'(0));
        end
        AES_data_out_valid = 1'b0;
        @(posedge AES_clk); #1;
        AES_data_out_valid = 1'b1;
        AES_data_out       = B1;
        expect_block("t6.fresh", B1, 0);
        AES_data_out_valid = 1'b0;
        expect_idle("t6.after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
